branch_flag_unit: RTL

//  Stage directly downstream of the ALU. Owns the architectural condition-code register (CCR) and

---
 rtl/branch_flag_unit_pkg.sv | 33 +++
 rtl/branch_flag_unit_if.sv | 33 +++
 rtl/branch_flag_unit_ccr_mask_decode.sv | 30 +++
 rtl/branch_flag_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/branch_flag_unit_pkg.sv
// Shared definitions for the branch/flag stage: opcode numbers, CCR bit positions
// and the stage FSM state type.
package branch_flag_unit_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_SETC = 1;
  localparam int unsigned OP_CLRC = 2;
  localparam int unsigned OP_NOT  = 3;
  localparam int unsigned OP_INC  = 4;
  localparam int unsigned OP_DEC  = 5;
  localparam int unsigned OP_ADD  = 9;
  localparam int unsigned OP_SUB  = 10;
  localparam int unsigned OP_AND  = 11;
  localparam int unsigned OP_OR   = 12;
  localparam int unsigned OP_SHL  = 13;
  localparam int unsigned OP_SHR  = 14;
  localparam int unsigned OP_JZ   = 20;
  localparam int unsigned OP_JN   = 21;
  localparam int unsigned OP_JC   = 22;
  localparam int unsigned OP_JMP  = 23;
  localparam int unsigned OP_RETI = 26;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_flag_unit_if.sv
// Bus between the ALU output register and the branch/flag stage, plus the
// stage's redirect/flush/interrupt outputs and FSM state for observation.
import branch_flag_unit_pkg::*;

// op_valid has no ready partner: the stage accepts every valid op in the cycle it
// is presented unless stall_in is high; outputs are registered one cycle later.
interface branch_flag_unit_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5
);
  logic              stall_in;
  logic              op_valid;
  logic [OP_W-1:0]   op_in;
  logic [3:0]        flags_in;
  logic [DATA_W-1:0] target_in;
  logic              int_req;
  logic [3:0]        ccr;
  logic              take_branch;
  logic [DATA_W-1:0] branch_target;
  logic              flush;
  logic              int_ack;
  state_t            state_dbg;

  modport master (
    output stall_in, op_valid, op_in, flags_in, target_in, int_req,
    input  ccr, take_branch, branch_target, flush, int_ack, state_dbg
  );

  modport slave (
    input  stall_in, op_valid, op_in, flags_in, target_in, int_req,
    output ccr, take_branch, branch_target, flush, int_ack, state_dbg
  );
endinterface

// File: rtl/branch_flag_unit_ccr_mask_decode.sv
// Opcode -> set of CCR bits the op is allowed to update. Pure combinational so the
// decode stage can reuse it for flag-hazard detection.
import branch_flag_unit_pkg::*;

module ccr_mask_decode #(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output logic [3:0]      mask
);
  always_comb begin
    mask = 4'b0000;
    case (op)
      OP_W'(OP_SETC), OP_W'(OP_CLRC), OP_W'(OP_SHL), OP_W'(OP_SHR): begin
        mask[FLAG_C] = 1'b1;
      end
      OP_W'(OP_NOT), OP_W'(OP_INC), OP_W'(OP_DEC), OP_W'(OP_AND), OP_W'(OP_OR): begin
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_N] = 1'b1;
      end
      OP_W'(OP_ADD): mask = 4'b1111;
      OP_W'(OP_SUB): begin
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_N] = 1'b1;
        mask[FLAG_V] = 1'b1;
      end
      default: mask = 4'b0000;
    endcase
  end
endmodule

// File: rtl/branch_flag_unit.sv
// Post-ALU stage: owns the CCR, resolves jumps against it, flushes wrong-path
// stages after a taken branch, and saves/restores CCR around interrupts.
import branch_flag_unit_pkg::*;

module branch_flag_unit #(
  parameter int DATA_W       = 16,
  parameter int OP_W         = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  branch_flag_unit_if.slave bus
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        ccr_q, ccr_d, shadow_q, shadow_d, mask, test_bit;
  logic              shadow_valid_q, shadow_valid_d;
  logic              take_q, take_d, ack_q, ack_d, flush_q, flush_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              live, is_jump, cond_ok, taken, is_reti, accept;

  ccr_mask_decode #(.OP_W(OP_W)) u_mask (.op(bus.op_in), .mask(mask));

  // Ops arriving during FLUSH are wrong-path and have no effect.
  assign live    = bus.op_valid && (state_q == ST_RUN) && !bus.stall_in;
  assign is_reti = live && (bus.op_in == OP_W'(OP_RETI));

  always_comb begin
    test_bit = 4'b0000;
    is_jump  = 1'b0;
    case (bus.op_in)
      OP_W'(OP_JZ):  begin is_jump = 1'b1; test_bit[FLAG_Z] = 1'b1; end
      OP_W'(OP_JN):  begin is_jump = 1'b1; test_bit[FLAG_N] = 1'b1; end
      OP_W'(OP_JC):  begin is_jump = 1'b1; test_bit[FLAG_C] = 1'b1; end
      OP_W'(OP_JMP): is_jump = 1'b1;
      default:       is_jump = 1'b0;
    endcase
    cond_ok = (test_bit == 4'b0000) || ((ccr_q & test_bit) != 4'b0000);
  end

  assign taken  = live && is_jump && cond_ok;
  assign accept = (state_q == ST_RUN) && !bus.stall_in && !taken && !shadow_valid_q
                  && bus.int_req && !is_reti;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (!bus.stall_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Registered-output next values
  always_comb begin
    ccr_d          = ccr_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    tgt_d          = tgt_q;
    take_d         = 1'b0;
    ack_d          = 1'b0;
    flush_d        = (state_d == ST_FLUSH);
    if (live) begin
      ccr_d = (ccr_q & ~mask) | (bus.flags_in & mask);
      if (taken) begin
        ccr_d  = ccr_d & ~test_bit;
        take_d = 1'b1;
        tgt_d  = bus.target_in;
      end
      if (is_reti && shadow_valid_q) begin
        ccr_d          = shadow_q;
        shadow_valid_d = 1'b0;
      end
    end
    // The saved copy includes this cycle's merge, so an op retiring alongside the ack is kept.
    if (accept) begin
      ack_d          = 1'b1;
      shadow_d       = ccr_d;
      shadow_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ccr_q          <= 4'b0000;
      shadow_q       <= 4'b0000;
      shadow_valid_q <= 1'b0;
      tgt_q          <= '0;
      take_q         <= 1'b0;
      ack_q          <= 1'b0;
      flush_q        <= 1'b0;
    end else if (bus.stall_in) begin
      take_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ccr_q          <= ccr_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      tgt_q          <= tgt_d;
      take_q         <= take_d;
      ack_q          <= ack_d;
      flush_q        <= flush_d;
    end
  end

  assign bus.ccr           = ccr_q;
  assign bus.take_branch   = take_q;
  assign bus.branch_target = tgt_q;
  assign bus.flush         = flush_q;
  assign bus.int_ack       = ack_q;
  assign bus.state_dbg     = state_q;
endmodule
